// File: rtl/ftdi_rx_fifo_reader.sv
// FT2232H synchronous-FIFO receive path: drains RXF#/RD#/OE# into a local
// first-word-fall-through FIFO and presents bytes on a valid/ready stream.
module ftdi_rx_fifo_reader #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK_FTDI,
    input  logic             RST_N,
    input  logic             RX_EMPTY,
    input  logic [7:0]       DATA_IN,
    input  logic             RX_EN,
    output logic             READ_N,
    output logic             OUT_EN,
    output logic             SEND_IM,
    output logic [7:0]       M_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [CNT_W-1:0] RX_BYTE_COUNT,
    output logic             OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        READ
    } state_e;

    state_e           state_q, state_d;
    logic             read_n_q, read_n_d;
    logic             oe_n_q, oe_n_d;
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             capture;
    logic             push;
    logic             pop;
    logic             space_ok;

    assign capture = !read_n_q && !RX_EMPTY;
    assign push    = capture && (occ_q != OCC_FULL);
    assign pop     = (occ_q != '0) && M_READY;

    assign occ_d    = occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
    // One slot stays free for the byte already in flight on the bus.
    assign space_ok = (occ_d < OCC_FULL);

    assign cnt_d = cnt_q + CNT_W'(capture);
    assign ovf_d = ovf_q || (capture && (occ_q == OCC_FULL));

    always_comb begin
        state_d  = state_q;
        read_n_d = read_n_q;
        oe_n_d   = oe_n_q;
        unique case (state_q)
            IDLE: begin
                read_n_d = 1'b1;
                oe_n_d   = 1'b1;
                if (RX_EN && !RX_EMPTY && space_ok) begin
                    state_d = TURN;
                    oe_n_d  = 1'b0;
                end
            end
            TURN: begin
                if (RX_EMPTY || !RX_EN) begin
                    state_d = IDLE;
                    oe_n_d  = 1'b1;
                end else begin
                    state_d  = READ;
                    read_n_d = 1'b0;
                end
            end
            READ: begin
                if (RX_EMPTY || !RX_EN || !space_ok) begin
                    state_d  = IDLE;
                    read_n_d = 1'b1;
                    oe_n_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                read_n_d = 1'b1;
                oe_n_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_FTDI or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            read_n_q <= 1'b1;
            oe_n_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            read_n_q <= read_n_d;
            oe_n_q   <= oe_n_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK_FTDI) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    assign READ_N        = read_n_q;
    assign OUT_EN        = oe_n_q;
    assign SEND_IM       = 1'b1;
    assign M_DATA        = mem_q[rd_ptr_q];
    assign M_VALID       = (occ_q != '0);
    assign RX_BYTE_COUNT = cnt_q;
    assign OVERFLOW      = ovf_q;

endmodule

// File: tb/tb_ftdi_rx_fifo_reader.sv
// Directed bench for ftdi_rx_fifo_reader: handshake timing, backpressure,
// burst termination, reset and counter wrap.
module tb_ftdi_rx_fifo_reader;

    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        RX_EMPTY = 1'b1;
    logic [7:0]  DATA_IN = 8'h00;
    logic        RX_EN = 1'b0;
    logic        READ_N;
    logic        OUT_EN;
    logic        SEND_IM;
    logic [7:0]  M_DATA;
    logic        M_VALID;
    logic        M_READY = 1'b0;
    logic [15:0] RX_BYTE_COUNT;
    logic        OVERFLOW;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ncap = 0;
    logic [7:0]  src_byte = 8'h00;
    logic [7:0]  exp_byte = 8'h00;

    always #5 clk = ~clk;

    ftdi_rx_fifo_reader #(
        .DEPTH(16),
        .CNT_W(16)
    ) dut (
        .CLK_FTDI     (clk),
        .RST_N        (RST_N),
        .RX_EMPTY     (RX_EMPTY),
        .DATA_IN      (DATA_IN),
        .RX_EN        (RX_EN),
        .READ_N       (READ_N),
        .OUT_EN       (OUT_EN),
        .SEND_IM      (SEND_IM),
        .M_DATA       (M_DATA),
        .M_VALID      (M_VALID),
        .M_READY      (M_READY),
        .RX_BYTE_COUNT(RX_BYTE_COUNT),
        .OVERFLOW     (OVERFLOW)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; advances one full clock.
    task automatic step();
        bit cap;
        bit pop;
        cap = !READ_N && !RX_EMPTY;
        pop = M_VALID && M_READY;
        DATA_IN = src_byte;
        if (pop) begin
            check("pop data", M_DATA, exp_byte);
            exp_byte++;
        end
        @(posedge clk);
        @(negedge clk);
        if (cap) begin
            src_byte++;
            ncap++;
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        RX_EMPTY = 1'b1;
        RX_EN = 1'b0;
        M_READY = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RST_N = 1'b1;
        ncap = 0;
    endtask

    task automatic run_to_ncap(input int target, input string tag);
        int g;
        g = 0;
        while (ncap < target && g < 100) begin
            step();
            g++;
        end
        check(tag, ncap, target);
    endtask

    initial begin
        int g;
        bit seen_low;

        // Reset asserted mid-burst acts without a clock edge
        do_reset();
        RX_EN = 1'b1;
        RX_EMPTY = 1'b0;
        src_byte = 8'h10;
        repeat (3) step();
        check("pre-reset READ_N", READ_N, 0);
        #2 RST_N = 1'b0;
        #1;
        check("rst READ_N", READ_N, 1);
        check("rst OUT_EN", OUT_EN, 1);
        check("rst M_VALID", M_VALID, 0);
        check("rst count", RX_BYTE_COUNT, 0);
        check("rst OVERFLOW", OVERFLOW, 0);
        check("rst SEND_IM", SEND_IM, 1);
        @(negedge clk);

        // Single byte handshake timing
        do_reset();
        src_byte = 8'hA5;
        exp_byte = 8'hA5;
        RX_EN = 1'b1;
        RX_EMPTY = 1'b0;
        step();
        check("single k OUT_EN", OUT_EN, 0);
        check("single k READ_N", READ_N, 1);
        step();
        check("single k+1 READ_N", READ_N, 0);
        check("single k+1 OUT_EN", OUT_EN, 0);
        check("single k+1 M_VALID", M_VALID, 0);
        step();
        check("single M_VALID", M_VALID, 1);
        check("single M_DATA", M_DATA, 8'hA5);
        check("single count", RX_BYTE_COUNT, 1);
        RX_EMPTY = 1'b1;
        step();
        check("single end READ_N", READ_N, 1);
        check("single end OUT_EN", OUT_EN, 1);
        check("single end count", RX_BYTE_COUNT, 1);
        M_READY = 1'b1;
        step();
        check("single drained", M_VALID, 0);
        check("single popped", exp_byte, 8'hA6);

        // Backpressure fills exactly DEPTH bytes, then resumes in order
        do_reset();
        src_byte = 8'h00;
        exp_byte = 8'h00;
        RX_EN = 1'b1;
        RX_EMPTY = 1'b0;
        g = 0;
        seen_low = 1'b0;
        while (g < 60 && !(seen_low && READ_N)) begin
            step();
            if (!READ_N) seen_low = 1'b1;
            g++;
        end
        check("bp burst ended", READ_N, 1);
        check("bp count", RX_BYTE_COUNT, 16);
        check("bp OVERFLOW", OVERFLOW, 0);
        check("bp head", M_DATA, 8'h00);
        repeat (4) step();
        check("bp hold OUT_EN", OUT_EN, 1);
        check("bp hold count", RX_BYTE_COUNT, 16);
        M_READY = 1'b1;
        step();
        check("bp resume TURN OUT_EN", OUT_EN, 0);
        check("bp resume TURN READ_N", READ_N, 1);
        g = 0;
        while (exp_byte != 8'd32 && g < 200) begin
            RX_EMPTY = (src_byte >= 8'd32);
            step();
            g++;
        end
        check("bp all popped", exp_byte, 32);
        check("bp total count", RX_BYTE_COUNT, 32);
        check("bp final OVERFLOW", OVERFLOW, 0);
        check("bp empty", M_VALID, 0);

        // RXF# rising ends the burst after 5 bytes
        do_reset();
        src_byte = 8'h40;
        exp_byte = 8'h40;
        RX_EN = 1'b1;
        M_READY = 1'b1;
        RX_EMPTY = 1'b0;
        run_to_ncap(5, "rxf reach 5");
        check("rxf READ_N still low", READ_N, 0);
        RX_EMPTY = 1'b1;
        step();
        check("rxf READ_N", READ_N, 1);
        check("rxf OUT_EN", OUT_EN, 1);
        check("rxf count", RX_BYTE_COUNT, 5);
        repeat (3) step();
        check("rxf idle OUT_EN", OUT_EN, 1);
        check("rxf popped", exp_byte, 8'h45);

        // RX_EN low during READ: capture on that edge still counts
        do_reset();
        src_byte = 8'h60;
        exp_byte = 8'h60;
        RX_EN = 1'b1;
        M_READY = 1'b1;
        RX_EMPTY = 1'b0;
        run_to_ncap(3, "rxen reach 3");
        RX_EN = 1'b0;
        step();
        check("rxen READ_N", READ_N, 1);
        check("rxen OUT_EN", OUT_EN, 1);
        check("rxen count", RX_BYTE_COUNT, 4);
        repeat (4) step();
        check("rxen stays idle", OUT_EN, 1);
        check("rxen no extra", RX_BYTE_COUNT, 4);
        check("rxen popped", exp_byte, 8'h64);

        // Counter wrap
        do_reset();
        force dut.cnt_q = 16'hFFFF;
        step();
        release dut.cnt_q;
        check("wrap preload", RX_BYTE_COUNT, 16'hFFFF);
        src_byte = 8'h80;
        exp_byte = 8'h80;
        RX_EN = 1'b1;
        M_READY = 1'b1;
        RX_EMPTY = 1'b0;
        run_to_ncap(2, "wrap reach 2");
        RX_EMPTY = 1'b1;
        step();
        check("wrap count", RX_BYTE_COUNT, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
